// File: rtl/nibble_pkg.sv
// Shared opcode and state definitions for the nibble processor execute stage.
package nibble_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_IN    = 4'h2;
  localparam logic [3:0] OP_OUT   = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_SUBI  = 4'h5;
  localparam logic [3:0] OP_CMPI  = 4'h6;
  localparam logic [3:0] OP_NANDI = 4'h7;
  localparam logic [3:0] OP_JC    = 4'h8;
  localparam logic [3:0] OP_JNC   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JNZ   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_NOPD  = 4'hD;
  localparam logic [3:0] OP_NOPE  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  function automatic logic is_jump(input logic [3:0] op);
    return (op >= OP_JC) && (op <= OP_JMP);
  endfunction

endpackage

// File: rtl/nibble_exec_unit_alu.sv
// Combinational ALU: computes the new accumulator/flags and which of them to write.
// IN is presented by the caller with data_in on the operand input, so it
// behaves exactly like LIT here.
module nibble_alu
  import nibble_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_oprnd,
  input  logic [3:0] i_op,
  output logic [3:0] o_result,
  output logic       o_c,
  output logic       o_z,
  output logic       o_a_we,
  output logic       o_c_we,
  output logic       o_z_we
);

  logic [4:0] w_sum;
  logic [4:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_oprnd};
  assign w_diff = {1'b0, i_a} - {1'b0, i_oprnd};

  // Opcode decode; bit 4 of the 5-bit difference is the borrow.
  always_comb begin
    o_result = i_a;
    o_c      = 1'b0;
    o_z      = 1'b0;
    o_a_we   = 1'b0;
    o_c_we   = 1'b0;
    o_z_we   = 1'b0;
    case (i_op)
      OP_LIT, OP_IN: begin
        o_result = i_oprnd;
        o_z      = (i_oprnd == 4'h0);
        o_a_we   = 1'b1;
        o_z_we   = 1'b1;
      end
      OP_ADDI: begin
        o_result = w_sum[3:0];
        o_c      = w_sum[4];
        o_z      = (w_sum[3:0] == 4'h0);
        o_a_we   = 1'b1;
        o_c_we   = 1'b1;
        o_z_we   = 1'b1;
      end
      OP_SUBI, OP_CMPI: begin
        o_result = w_diff[3:0];
        o_c      = w_diff[4];
        o_z      = (w_diff[3:0] == 4'h0);
        o_a_we   = (i_op == OP_SUBI);
        o_c_we   = 1'b1;
        o_z_we   = 1'b1;
      end
      OP_NANDI: begin
        o_result = ~(i_a & i_oprnd);
        o_z      = (~(i_a & i_oprnd) == 4'h0);
        o_a_we   = 1'b1;
        o_z_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nibble_exec_unit.sv
// Fetch/execute sequencer for the nibble processor; owns A, C, Z and the output port.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_FETCH | fetch register loads ROM[pc], pc increments
//   ST_EXEC  | latched instruction executes; jumps steer the pc
//   ST_HALT  | everything frozen until reset
module nibble_exec_unit
  import nibble_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  instr,
  input  logic [3:0]  oprnd,
  input  logic [7:0]  program_byte,
  input  logic [3:0]  data_in,
  output logic        fetch_en,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [11:0] pc_addr,
  output logic [3:0]  data_out,
  output logic        out_strobe,
  output logic [3:0]  acc,
  output logic        carry,
  output logic        zero,
  output logic        phase,
  output logic        halted
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_acc;
  logic       r_carry;
  logic       r_zero;
  logic [3:0] r_data_out;
  logic       r_out_strobe;
  logic       w_take;

  logic [3:0] w_alu_oprnd;
  logic [3:0] w_alu_result;
  logic       w_alu_c;
  logic       w_alu_z;
  logic       w_a_we;
  logic       w_c_we;
  logic       w_z_we;

  assign w_alu_oprnd = (instr == OP_IN) ? data_in : oprnd;

  nibble_alu u_alu (
    .i_a      (r_acc),
    .i_oprnd  (w_alu_oprnd),
    .i_op     (instr),
    .o_result (w_alu_result),
    .o_c      (w_alu_c),
    .o_z      (w_alu_z),
    .o_a_we   (w_a_we),
    .o_c_we   (w_c_we),
    .o_z_we   (w_z_we)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  // Next state and pc/fetch control; jumps resolve against the current flags.
  always_comb begin
    w_next   = r_state;
    fetch_en = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    pc_addr  = 12'h000;
    w_take   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        fetch_en = 1'b1;
        pc_inc   = 1'b1;
        w_next   = ST_EXEC;
      end
      ST_EXEC: begin
        w_next = (instr == OP_HALT) ? ST_HALT : ST_FETCH;
        case (instr)
          OP_JC:   w_take = r_carry;
          OP_JNC:  w_take = ~r_carry;
          OP_JZ:   w_take = r_zero;
          OP_JNZ:  w_take = ~r_zero;
          OP_JMP:  w_take = 1'b1;
          default: w_take = 1'b0;
        endcase
        if (is_jump(instr)) begin
          if (w_take) begin
            pc_load = 1'b1;
            pc_addr = {oprnd, program_byte};
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  // Architectural registers commit only on the edge leaving EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc        <= 4'h0;
      r_carry      <= 1'b0;
      r_zero       <= 1'b0;
      r_data_out   <= 4'h0;
      r_out_strobe <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      if (w_a_we) r_acc   <= w_alu_result;
      if (w_c_we) r_carry <= w_alu_c;
      if (w_z_we) r_zero  <= w_alu_z;
      if (instr == OP_OUT) r_data_out <= r_acc;
      r_out_strobe <= (instr == OP_OUT);
    end else begin
      r_out_strobe <= 1'b0;
    end
  end

  assign acc        = r_acc;
  assign carry      = r_carry;
  assign zero       = r_zero;
  assign data_out   = r_data_out;
  assign out_strobe = r_out_strobe;
  assign phase      = (r_state == ST_EXEC);
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_nibble_exec_unit.sv
// Randomized bench for nibble_exec_unit against an instruction-level model.
module tb_nibble_exec_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [7:0]  program_byte;
  logic [3:0]  data_in;
  logic        fetch_en;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_addr;
  logic [3:0]  data_out;
  logic        out_strobe;
  logic [3:0]  acc;
  logic        carry;
  logic        zero;
  logic        phase;
  logic        halted;

  int n_total = 0;
  int n_bad   = 0;

  // instruction-level architectural model
  int m_a, m_c, m_z, m_dout, m_strobe;

  always #5 clock = ~clock;

  nibble_exec_unit dut (
    .clock        (clock),
    .reset        (reset),
    .instr        (instr),
    .oprnd        (oprnd),
    .program_byte (program_byte),
    .data_in      (data_in),
    .fetch_en     (fetch_en),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_addr      (pc_addr),
    .data_out     (data_out),
    .out_strobe   (out_strobe),
    .acc          (acc),
    .carry        (carry),
    .zero         (zero),
    .phase        (phase),
    .halted       (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_a = 0; m_c = 0; m_z = 0; m_dout = 0; m_strobe = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_acc"},   acc,      m_a);
    check({tag, "_carry"}, carry,    m_c);
    check({tag, "_zero"},  zero,     m_z);
    check({tag, "_dout"},  data_out, m_dout);
  endtask

  // Called at a FETCH sample point; runs one full instruction.
  task automatic run_instr(input int op, input int opr, input int pb, input int din);
    int taken;
    int isj;
    int d;
    check("fetch_phase", {halted, phase}, 2'b00);
    check("fetch_ctl", {fetch_en, pc_inc, pc_load}, 3'b110);
    check("fetch_addr", pc_addr, 0);
    check("strobe", out_strobe, m_strobe);
    instr = op[3:0]; oprnd = opr[3:0]; program_byte = pb[7:0]; data_in = din[3:0];
    step();
    check("exec_phase", {halted, phase}, 2'b01);
    isj = (op >= 8 && op <= 12);
    case (op)
      8:  taken = m_c;
      9:  taken = !m_c;
      10: taken = m_z;
      11: taken = !m_z;
      12: taken = 1;
      default: taken = 0;
    endcase
    check("exec_ctl", {fetch_en, pc_inc, pc_load}, {1'b0, 1'(isj && !taken), 1'(isj && taken)});
    check("exec_addr", pc_addr, (isj && taken) ? (opr * 256 + pb) : 0);
    if (op == 15) begin
      step();
      check("halted", {halted, phase}, 2'b10);
      for (int i = 0; i < 20; i++) begin
        check("halt_quiet", {fetch_en, pc_inc, pc_load, out_strobe}, 4'b0000);
        check_regs("halt_hold");
        step();
      end
      return;
    end
    case (op)
      1: begin m_a = opr; m_z = (m_a == 0); end
      2: begin m_a = din; m_z = (m_a == 0); end
      3: m_dout = m_a;
      4: begin d = m_a + opr; m_c = (d > 15); m_a = d % 16; m_z = (m_a == 0); end
      5: begin m_c = (m_a < opr); m_a = (m_a - opr + 16) % 16; m_z = (m_a == 0); end
      6: begin m_c = (m_a < opr); m_z = (((m_a - opr + 16) % 16) == 0); end
      7: begin m_a = 15 - (m_a & opr); m_z = (m_a == 0); end
      default: ;
    endcase
    m_strobe = (op == 3);
    step();
    check_regs("post");
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    instr = 4'h0;
    oprnd = 4'h0;
    @(negedge clock);
    #1;
    check("reset_async", {acc, carry, zero, data_out, out_strobe, phase, halted}, 0);
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    instr = 4'h0; oprnd = 4'h0; program_byte = 8'h00; data_in = 4'h0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    #1;
    check_regs("reset");
    check("reset_flags", {out_strobe, phase, halted}, 3'b000);

    // first EXEC decodes instr=0 as NOP
    run_instr(0, 0, 0, 0);
    run_instr(1, 15, 0, 0);
    run_instr(4, 1, 0, 0);
    check("addi_wrap", {acc, carry, zero}, {4'h0, 1'b1, 1'b1});
    run_instr(6, 1, 0, 0);
    check("cmpi", {acc, carry, zero}, {4'h0, 1'b1, 1'b0});
    run_instr(2, 0, 0, 10);
    run_instr(3, 0, 0, 0);
    check("out_val", data_out, 4'hA);
    run_instr(0, 0, 0, 0);
    // carry set, then taken and not-taken JC
    run_instr(1, 15, 0, 0);
    run_instr(4, 1, 0, 0);
    run_instr(8, 3, 8'h45, 0);
    run_instr(6, 0, 0, 0);
    run_instr(8, 3, 8'h45, 0);

    for (int i = 0; i < 300; i++)
      run_instr($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 15));

    // reset in the middle of an ADDI execute
    do_reset();
    check("pre_abort_phase", phase, 1'b0);
    instr = 4'h4; oprnd = 4'h5;
    step();
    check("abort_in_exec", phase, 1'b1);
    reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
    #1;
    model_reset();
    check_regs("abort");
    check("abort_state", {halted, phase}, 2'b00);
    run_instr(1, 7, 0, 0);
    run_instr(3, 0, 0, 0);

    run_instr(15, 0, 0, 0);
    do_reset();
    check("after_halt", {halted, phase, fetch_en, pc_inc}, 4'b0011);
    run_instr(1, 9, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
